// File: rtl/vga_pkg.sv
// Shared VGA constants: default 640x480@60 timing, colour widths, pattern
// encodings and the counter-width helper used by the timing generator.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_R_W = 3;
    localparam int DEF_G_W = 3;
    localparam int DEF_B_W = 2;

    typedef enum logic [1:0] {
        PAT_PASS    = 2'd0,
        PAT_BARS    = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_WHITE   = 2'd3
    } pattern_e;

    // Bits needed to hold 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One timing axis: free-running counter that wraps at the axis total, plus
// decode of the sync window and the active (visible) window.
module vga_axis_cnt
    import vga_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int W      = cnt_width(ACTIVE + FP + SYNC + BP)
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         adv,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         sync_act,
    output logic         active
);

    localparam int TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam int SYNC_START = ACTIVE + FP;
    localparam int SYNC_END   = SYNC_START + SYNC;
    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    generate
        if (ACTIVE < 1 || SYNC < 1 || FP < 0 || BP < 0) begin : g_bad_timing
            $error("vga_axis_cnt: ACTIVE and SYNC must be >= 1, porches >= 0");
        end
    endgenerate

    int cnt_i;

    assign cnt_i    = int'(cnt);
    assign wrap     = (cnt == LAST);
    assign sync_act = (cnt_i >= SYNC_START) && (cnt_i < SYNC_END);
    assign active   = (cnt_i < ACTIVE);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt <= '0;
        end else if (adv) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: h/v counters, registered syncs, data-enable, colour
// and line/frame pulses. Define VGA_TEST_PATTERN_EN to enable built-in patterns.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   R_W       = DEF_R_W,
    parameter int   G_W       = DEF_G_W,
    parameter int   B_W       = DEF_B_W,
    localparam int  H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int  HW        = cnt_width(H_TOTAL),
    localparam int  VW        = cnt_width(V_TOTAL)
) (
    input  logic          app_clk,
    input  logic          app_arst_n,
    input  logic          enable,
    input  logic [1:0]    pattern_sel,
    input  logic [R_W-1:0] pix_r,
    input  logic [G_W-1:0] pix_g,
    input  logic [B_W-1:0] pix_b,
    output logic [HW-1:0] x_pos,
    output logic [VW-1:0] y_pos,
    output logic          hsync,
    output logic          vsync,
    output logic [R_W-1:0] red,
    output logic [G_W-1:0] green,
    output logic [B_W-1:0] blue,
    output logic          de,
    output logic          frame_start,
    output logic          line_start
);

    logic h_wrap, h_sync_act, h_active;
    logic v_wrap_unused, v_sync_act, v_active;

    vga_axis_cnt #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(HW)
    ) u_h_axis (
        .clk(app_clk), .arst_n(app_arst_n), .adv(enable),
        .cnt(x_pos), .wrap(h_wrap), .sync_act(h_sync_act), .active(h_active)
    );

    // The vertical axis steps only on the last pixel of a line, so both axes
    // return to zero on the same edge at the end of a frame.
    vga_axis_cnt #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(VW)
    ) u_v_axis (
        .clk(app_clk), .arst_n(app_arst_n), .adv(enable & h_wrap),
        .cnt(y_pos), .wrap(v_wrap_unused), .sync_act(v_sync_act), .active(v_active)
    );

    logic           de_p0, h_zero_p0, v_zero_p0;
    logic [R_W-1:0] col_r_p0;
    logic [G_W-1:0] col_g_p0;
    logic [B_W-1:0] col_b_p0;

    assign de_p0     = h_active & v_active;
    assign h_zero_p0 = (x_pos == '0);
    assign v_zero_p0 = (y_pos == '0);

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    int         bar_idx;
    logic [2:0] bar_p0;
    logic       checker_p0;

    assign bar_idx    = int'(x_pos) / BAR_W;
    assign bar_p0     = (bar_idx > 7) ? 3'd7 : 3'(bar_idx);
    assign checker_p0 = ((int'(x_pos) ^ int'(y_pos)) & 8) != 0;
`else
    logic sel_unused;
    assign sel_unused = ^pattern_sel;
`endif

    always_comb begin
        col_r_p0 = pix_r;
        col_g_p0 = pix_g;
        col_b_p0 = pix_b;
`ifdef VGA_TEST_PATTERN_EN
        case (pattern_e'(pattern_sel))
            PAT_BARS: begin
                col_r_p0 = {R_W{bar_p0[2]}};
                col_g_p0 = {G_W{bar_p0[1]}};
                col_b_p0 = {B_W{bar_p0[0]}};
            end
            PAT_CHECKER: begin
                col_r_p0 = {R_W{checker_p0}};
                col_g_p0 = {G_W{checker_p0}};
                col_b_p0 = {B_W{checker_p0}};
            end
            PAT_WHITE: begin
                col_r_p0 = '1;
                col_g_p0 = '1;
                col_b_p0 = '1;
            end
            default: ;
        endcase
`endif
    end

    // p0 -> output registers: everything lags the counters by one clock
    always_ff @(posedge app_clk or negedge app_arst_n) begin
        if (!app_arst_n) begin
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            de          <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            hsync       <= h_sync_act ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= v_sync_act ? VSYNC_POL : ~VSYNC_POL;
            de          <= de_p0;
            red         <= de_p0 ? col_r_p0 : '0;
            green       <= de_p0 ? col_g_p0 : '0;
            blue        <= de_p0 ? col_b_p0 : '0;
            frame_start <= enable & h_zero_p0 & v_zero_p0;
            line_start  <= enable & h_zero_p0 & v_active;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: scaled timing with a cycle model, plus a tiny
// instance for the simultaneous-wrap case. Honours VGA_TEST_PATTERN_EN.
module tb_vga_timing_gen;

    localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
    localparam int VA = 16, VFP = 2, VS = 2, VBP = 3;
    localparam int HT = HA + HFP + HS + HBP;   // 80
    localparam int VT = VA + VFP + VS + VBP;   // 23
    localparam int FRAME = HT * VT;            // 1840

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic [1:0] pattern_sel = 2'd0;
    logic [2:0] pix_r, pix_g;
    logic [1:0] pix_b;
    logic [6:0] x_pos;
    logic [4:0] y_pos;
    logic       hsync, vsync, de, frame_start, line_start;
    logic [2:0] red, green;
    logic [1:0] blue;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .R_W(3), .G_W(3), .B_W(2)
    ) dut (
        .app_clk(clk), .app_arst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .x_pos(x_pos), .y_pos(y_pos),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
        .de(de), .frame_start(frame_start), .line_start(line_start)
    );

    // Tiny timing: 7 x 5 = 35 cycles per frame.
    logic [2:0] s_x, s_y, s_red, s_green;
    logic [1:0] s_blue;
    logic       s_hsync, s_vsync, s_de, s_fs, s_ls;
    logic [2:0] s_pix_r = 3'd0, s_pix_g = 3'd0;
    logic [1:0] s_pix_b = 2'd0;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_small (
        .app_clk(clk), .app_arst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
        .pix_r(s_pix_r), .pix_g(s_pix_g), .pix_b(s_pix_b), .x_pos(s_x), .y_pos(s_y),
        .hsync(s_hsync), .vsync(s_vsync), .red(s_red), .green(s_green), .blue(s_blue),
        .de(s_de), .frame_start(s_fs), .line_start(s_ls)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Upstream pixel source: a simple function of position.
    function automatic logic [2:0] fr(input int h, input int v);
        return 3'((h + v) & 7);
    endfunction
    function automatic logic [2:0] fg(input int h, input int v);
        return 3'(((h >> 3) + (v * 0)) & 7);
    endfunction
    function automatic logic [1:0] fb(input int h, input int v);
        return 2'((v + (h * 0)) & 3);
    endfunction

    always_comb begin
        pix_r = fr(int'(x_pos), int'(y_pos));
        pix_g = fg(int'(x_pos), int'(y_pos));
        pix_b = fb(int'(x_pos), int'(y_pos));
    end

    task automatic model_colour(input int h, input int v, input logic [1:0] sel,
                                output logic [2:0] r, output logic [2:0] g, output logic [1:0] b);
        logic [2:0] k;
        r = fr(h, v); g = fg(h, v); b = fb(h, v);
        k = 3'(h / (HA / 8));
`ifdef VGA_TEST_PATTERN_EN
        case (sel)
            2'd1: begin r = {3{k[2]}}; g = {3{k[1]}}; b = {2{k[0]}}; end
            2'd2: begin
                if ((((h >> 3) ^ (v >> 3)) & 1) != 0) begin r = 3'h7; g = 3'h7; b = 2'h3; end
                else begin r = 3'h0; g = 3'h0; b = 2'h0; end
            end
            2'd3: begin r = 3'h7; g = 3'h7; b = 2'h3; end
            default: ;
        endcase
`else
        if (sel == 2'd3 && k == 3'd0) r = fr(h, v);
`endif
    endtask

    // Model: t counts enabled cycles since reset; position is plain arithmetic on t.
    int         t = 0;
    logic       e_hsync = 1'b1, e_vsync = 1'b0, e_de = 1'b0, e_fs = 1'b0, e_ls = 1'b0;
    logic [2:0] e_r = 3'd0, e_g = 3'd0;
    logic [1:0] e_b = 2'd0;

    always @(posedge clk or negedge rst_n) begin : model
        int h, v;
        if (!rst_n) begin
            t = 0;
            e_hsync = 1'b1; e_vsync = 1'b0; e_de = 1'b0; e_fs = 1'b0; e_ls = 1'b0;
            e_r = 3'd0; e_g = 3'd0; e_b = 2'd0;
        end else begin
            h = t % HT;
            v = (t / HT) % VT;
            e_hsync = (h >= HA + HFP && h < HA + HFP + HS) ? 1'b0 : 1'b1;
            e_vsync = (v >= VA + VFP && v < VA + VFP + VS) ? 1'b1 : 1'b0;
            e_de    = (h < HA) && (v < VA);
            model_colour(h, v, pattern_sel, e_r, e_g, e_b);
            if (!e_de) begin e_r = 3'd0; e_g = 3'd0; e_b = 2'd0; end
            e_ls = enable && h == 0 && v < VA;
            e_fs = enable && h == 0 && v == 0;
            if (enable) t = t + 1;
        end
    end

    always @(negedge clk) begin
        check("x_pos", int'(x_pos), t % HT);
        check("y_pos", int'(y_pos), (t / HT) % VT);
        check("hsync", int'(hsync), int'(e_hsync));
        check("vsync", int'(vsync), int'(e_vsync));
        check("de", int'(de), int'(e_de));
        check("red", int'(red), int'(e_r));
        check("green", int'(green), int'(e_g));
        check("blue", int'(blue), int'(e_b));
        check("frame_start", int'(frame_start), int'(e_fs));
        check("line_start", int'(line_start), int'(e_ls));
    end

    // Bounded wait for a position (y < 0 means any line).
    task automatic wait_xy(input int x, input int y, input int budget, input string tag);
        bit hit = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (int'(x_pos) == x && (y < 0 || int'(y_pos) == y)) begin
                hit = 1'b1;
                break;
            end
        end
        check(tag, int'(hit), 1);
    endtask

    initial begin
        int found, fs_cnt, ls_cnt, de_cnt, hs_cnt, vs_cnt, first_hs, run, max_run;

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_x", int'(x_pos), 0);
        check("rst_fs", int'(frame_start), 0);
        check("rst_hsync", int'(hsync), 1);

        // First enabled edge: frame_start with the first de cycle.
        @(negedge clk);
        check("lit_fs_first", int'(frame_start), 1);
        check("lit_de_first", int'(de), 1);
        check("lit_ls_first", int'(line_start), 1);
        check("lit_x_first", int'(x_pos), 1);
        check("lit_vsync_first", int'(vsync), 0);

        found = 0;
        for (int n = 2; n <= 40; n++) begin
            @(negedge clk);
            if (n == 34) begin
                check("small_x_last", int'(s_x), 6);
                check("small_y_last", int'(s_y), 4);
            end
            if (s_x == 3'd0 && s_y == 3'd0) begin
                found = n;
                break;
            end
        end
        check("small_wrap_cycles", found, 35);

        // One full frame of statistics starting at a frame_start pulse.
        pattern_sel = 2'd1;
        begin
            bit hit = 1'b0;
            for (int n = 0; n < 2 * FRAME; n++) begin
                @(negedge clk);
                if (frame_start) begin hit = 1'b1; break; end
            end
            check("wait_frame_start", int'(hit), 1);
        end
        fs_cnt = 0; ls_cnt = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        first_hs = -1; run = 0; max_run = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk);
            fs_cnt += int'(frame_start);
            ls_cnt += int'(line_start);
            de_cnt += int'(de);
            vs_cnt += int'(vsync);
            if (!hsync) begin
                hs_cnt++;
                run++;
                if (first_hs < 0) first_hs = i;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
        check("frame_fs_count", fs_cnt, 1);
        check("frame_ls_count", ls_cnt, 16);
        check("frame_de_count", de_cnt, 1024);
        check("frame_hsync_cycles", hs_cnt, 184);
        check("frame_vsync_cycles", vs_cnt, 160);
        check("hsync_first_index", first_hs, 68);
        check("hsync_run", max_run, 8);

        // Output for pixel (8,1) is visible when the counter shows (9,1).
        wait_xy(9, 1, 2 * FRAME, "wait_px8");
`ifdef VGA_TEST_PATTERN_EN
        check("bar1_red", int'(red), 0);
        check("bar1_green", int'(green), 0);
        check("bar1_blue", int'(blue), 3);
`else
        check("pass_red", int'(red), 1);
        check("pass_green", int'(green), 1);
        check("pass_blue", int'(blue), 1);
`endif
        wait_xy(65, 1, HT, "wait_blank");
        check("blank_red", int'(red), 0);
        check("blank_blue", int'(blue), 0);
        check("blank_de", int'(de), 0);

        // Freeze mid-line for 10 cycles.
        pattern_sel = 2'd0;
        wait_xy(20, -1, 2 * HT, "wait_x20");
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("freeze_x", int'(x_pos), 20);
            check("freeze_fs", int'(frame_start), 0);
            check("freeze_ls", int'(line_start), 0);
        end
        enable = 1'b1;
        @(negedge clk);
        check("resume_x", int'(x_pos), 21);

        // Freeze on the first pixel of a line: no pulse until it advances again.
        wait_xy(0, 2, 2 * FRAME, "wait_line2");
        enable = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("freeze0_ls", int'(line_start), 0);
        end
        enable = 1'b1;
        @(negedge clk);
        check("resume0_ls", int'(line_start), 1);
        check("resume0_x", int'(x_pos), 1);

        // Asynchronous reset in the middle of a frame.
        wait_xy(30, 10, 2 * FRAME, "wait_30_10");
        #1 rst_n = 1'b0;
        #1;
        check("arst_x", int'(x_pos), 0);
        check("arst_y", int'(y_pos), 0);
        check("arst_hsync", int'(hsync), 1);
        check("arst_vsync", int'(vsync), 0);
        check("arst_de", int'(de), 0);
        check("arst_colour", int'({red, green, blue}), 0);
        check("arst_pulses", int'({frame_start, line_start}), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rel_fs_before_edge", int'(frame_start), 0);
        @(negedge clk);
        check("rel_fs", int'(frame_start), 1);
        check("rel_x", int'(x_pos), 1);

        pattern_sel = 2'd2;
        repeat (FRAME) @(negedge clk);
        pattern_sel = 2'd3;
        repeat (400) @(negedge clk);
        pattern_sel = 2'd0;
        repeat (200) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
